// File: rtl/i2s_tx_stereo_fifo.sv
// Stereo I2S transmitter with a small stereo-pair input FIFO and programmable underrun silence.
// Define I2S_UNDERRUN_CNT_EN to add a saturating 16-bit underrun_count output.
module i2s_tx_stereo_fifo #(
   parameter int DATA_W     = 12,
   parameter int SLOT_W     = 13,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          s_clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             silence,
   input  logic [DATA_W-1:0]             in_left,
   input  logic [DATA_W-1:0]             in_right,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          word_select,
   output logic                          sound_bit_out,
`ifdef I2S_UNDERRUN_CNT_EN
   output logic                          underrun,
   output logic [15:0]                   underrun_count
`else
   output logic                          underrun
`endif
);

   localparam int FRAME = 2 * SLOT_W;
   localparam int PW    = $clog2(FRAME);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = AW + 1;
   localparam int IW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   generate
      if (SLOT_W < DATA_W + 1) begin : g_bad_slot
         $error("i2s_tx_stereo_fifo: SLOT_W must be >= DATA_W+1");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("i2s_tx_stereo_fifo: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   logic [PW-1:0]     pos;
   logic [PW-1:0]     pos_next;
   logic              frame_end;
   logic [DATA_W-1:0] left_q;
   logic [DATA_W-1:0] right_q;
   logic [DATA_W-1:0] left_mem  [FIFO_DEPTH];
   logic [DATA_W-1:0] right_mem [FIFO_DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              next_bit;
   logic              next_ws;
   logic [IW-1:0]     bit_idx;
   int                pos_i;

   assign frame_end  = (pos == PW'(FRAME - 1));
   assign pos_next   = frame_end ? '0 : pos + PW'(1);
   assign fifo_empty = (fifo_level == '0);
   assign in_ready   = (fifo_level != LW'(FIFO_DEPTH));
   assign push       = in_valid && in_ready;
   assign pop        = frame_end && !fifo_empty;

   // Outputs are registered, so the bit is chosen from the position about to be entered.
   always_comb begin
      pos_i    = int'(pos_next);
      next_ws  = (pos_i >= SLOT_W);
      next_bit = 1'b0;
      bit_idx  = '0;
      if (pos_i >= 1 && pos_i <= DATA_W) begin
         bit_idx  = IW'(DATA_W - pos_i);
         next_bit = left_q[bit_idx];
      end else if (pos_i >= SLOT_W + 1 && pos_i <= SLOT_W + DATA_W) begin
         bit_idx  = IW'(SLOT_W + DATA_W - pos_i);
         next_bit = right_q[bit_idx];
      end
   end

   // Shadow registers reload only at the frame wrap; reset keeps tracking the silence word.
   always_ff @(posedge s_clk or negedge reset) begin
      if (!reset) begin
         pos           <= '0;
         word_select   <= 1'b0;
         sound_bit_out <= 1'b0;
         underrun      <= 1'b0;
         left_q        <= silence;
         right_q       <= silence;
      end else begin
         pos           <= pos_next;
         word_select   <= next_ws;
         sound_bit_out <= next_bit;
         underrun      <= frame_end && fifo_empty;
         if (frame_end) begin
            if (fifo_empty) begin
               left_q  <= silence;
               right_q <= silence;
            end else begin
               left_q  <= left_mem[rd_ptr];
               right_q <= right_mem[rd_ptr];
            end
         end
      end
   end

   always_ff @(posedge s_clk) begin
      if (push) begin
         left_mem[wr_ptr]  <= in_left;
         right_mem[wr_ptr] <= in_right;
      end
   end

   always_ff @(posedge s_clk or negedge reset) begin
      if (!reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

`ifdef I2S_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;

   always_ff @(posedge s_clk or negedge reset) begin
      if (!reset) begin
         underrun_cnt <= '0;
      end else if (underrun && underrun_cnt != 16'hFFFF) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end

   assign underrun_count = underrun_cnt;
`endif

endmodule
